// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bundle bit positions, ALU op codes,
// and the hardwired-zero register address.
package pipe_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside the packed control bundle
  // {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[3:0]}
  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_DST    = 4;
  localparam int CTRL_ALUOP_MSB  = 3;
  localparam int CTRL_ALUOP_LSB  = 0;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_XOR = 4'd4;
  localparam logic [3:0] ALUOP_NOR = 4'd5;
  localparam logic [3:0] ALUOP_SLT = 4'd6;
  localparam logic [3:0] ALUOP_SLL = 4'd7;
  localparam logic [3:0] ALUOP_SRL = 4'd8;
  localparam logic [3:0] ALUOP_LUI = 4'd9;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic [4:0] resolve_wr_addr(input logic       reg_dst,
                                                 input logic [4:0] rd,
                                                 input logic [4:0] rt);
    return reg_dst ? rd : rt;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the decode slot.
// A taken branch kills the decode instruction, so it suppresses the stall.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_wr_addr_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       flush_i,
  output logic       stall_o
);

  // rt is compared even for instructions that do not read it; the extra stall is harmless
  assign stall_o = !flush_i && ex_valid_i && ex_mem_read_i && id_valid_i &&
                   (ex_wr_addr_i != REG_ZERO) &&
                   ((ex_wr_addr_i == id_rs_i) || (ex_wr_addr_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures negedge register-file operands and decode
// control on posedge, inserts one bubble per load-use hazard, and counts them.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rdData1,
  input  logic [DATA_W-1:0] id_rdData2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wrAddr,
  output logic [DATA_W-1:0] ex_rdData1,
  output logic [DATA_W-1:0] ex_rdData2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q, valid_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_bubble;

  load_use_detect u_lud (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEM_READ]),
    .ex_wr_addr_i  (wr_q),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .flush_i       (flush),
    .stall_o       (stall)
  );

  // flush beats hold; stall only takes effect when not held (and is already 0 under flush)
  assign load_bubble = flush || (!hold && stall);

  always_comb begin
    valid_d = valid_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wr_d    = wr_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    imm_d   = imm_q;
    pc4_d   = pc4_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      rs_d    = '0;
      rt_d    = '0;
      wr_d    = '0;
      d1_d    = '0;
      d2_d    = '0;
      imm_d   = '0;
      pc4_d   = '0;
      ctrl_d  = '0;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!hold) begin
      valid_d = id_valid;
      rs_d    = id_rs;
      rt_d    = id_rt;
      wr_d    = resolve_wr_addr(id_ctrl[CTRL_REG_DST], id_rd, id_rt);
      d1_d    = id_rdData1;
      d2_d    = id_rdData2;
      imm_d   = id_imm;
      pc4_d   = id_pc4;
      ctrl_d  = id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      wr_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wr_q    <= wr_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_wrAddr  = wr_q;
  assign ex_rdData1 = d1_q;
  assign ex_rdData2 = d2_q;
  assign ex_imm     = imm_q;
  assign ex_pc4     = pc4_q;
  assign ex_ctrl    = ctrl_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/flush/hold/reset cases then
// random traffic, checked against a behavioural model of the EX slot.
module tb_id_ex_stage;

  localparam logic [9:0] CT_ADD = 10'h210; // regWrite | regDst
  localparam logic [9:0] CT_LW  = 10'h360; // regWrite | memRead | memToReg | aluSrc

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [31:0] id_rdData1 = '0, id_rdData2 = '0, id_imm = '0, id_pc4 = '0;
  logic [9:0]  id_ctrl = '0;
  logic        flush = 1'b0, hold = 1'b0;

  logic        stall, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_wrAddr;
  logic [31:0] ex_rdData1, ex_rdData2, ex_imm, ex_pc4;
  logic [9:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_stall, s_ex_valid;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_wrAddr;
  logic [31:0] s_ex_rdData1, s_ex_rdData2, s_ex_imm, s_ex_pc4;
  logic [9:0]  s_ex_ctrl;
  logic [1:0]  s_bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CTRL_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdData1(id_rdData1), .id_rdData2(id_rdData2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wrAddr(ex_wrAddr), .ex_rdData1(ex_rdData1),
    .ex_rdData2(ex_rdData2), .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_ctrl(ex_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DATA_W(32), .CTRL_W(10), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdData1(id_rdData1), .id_rdData2(id_rdData2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold), .stall(s_stall), .ex_valid(s_ex_valid),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_wrAddr(s_ex_wrAddr), .ex_rdData1(s_ex_rdData1),
    .ex_rdData2(s_ex_rdData2), .ex_imm(s_ex_imm), .ex_pc4(s_ex_pc4), .ex_ctrl(s_ex_ctrl),
    .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, wr;
    logic [31:0] d1, d2, imm, pc4;
    logic [9:0]  ctrl;
    int          cnt;
    int          cnt2;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t empty_slot(input int cnt, input int cnt2);
    exp_t e;
    e.v = 1'b0; e.rs = '0; e.rt = '0; e.wr = '0;
    e.d1 = '0; e.d2 = '0; e.imm = '0; e.pc4 = '0; e.ctrl = '0;
    e.cnt = cnt; e.cnt2 = cnt2;
    return e;
  endfunction

  // A load in EX whose real destination is read by a live decode instruction
  function automatic bit model_stall();
    return !flush && m.v && m.ctrl[8] && id_valid && (m.wr != 5'd0) &&
           ((m.wr == id_rs) || (m.wr == id_rt));
  endfunction

  function automatic exp_t model_next(input bit s);
    exp_t n;
    n = m;
    if (flush) begin
      n = empty_slot(m.cnt, m.cnt2);
    end else if (hold) begin
      n = m;
    end else if (s) begin
      n = empty_slot((m.cnt < 65535) ? m.cnt + 1 : m.cnt, (m.cnt2 < 3) ? m.cnt2 + 1 : m.cnt2);
    end else begin
      n.v    = id_valid;
      n.rs   = id_rs;
      n.rt   = id_rt;
      n.wr   = id_ctrl[4] ? id_rd : id_rt;
      n.d1   = id_rdData1;
      n.d2   = id_rdData2;
      n.imm  = id_imm;
      n.pc4  = id_pc4;
      n.ctrl = id_valid ? id_ctrl : 10'd0;
    end
    return n;
  endfunction

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [9:0] ct, input logic fl, input logic hd);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdData1 = d1; id_rdData2 = d2;
    id_imm = d1 ^ 32'h0000_ffff; id_pc4 = d2 + 32'd4;
    id_ctrl = ct; flush = fl; hold = hd;
  endtask

  // One decode cycle: drive at negedge, check stall, queue the expected EX slot
  task automatic apply(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [9:0] ct, input logic fl, input logic hd);
    bit s;
    @(negedge clk);
    rst = 1'b0;
    set_in(v, rs, rt, rd, d1, d2, ct, fl, hd);
    #1;
    s = model_stall();
    chk("stall", {63'd0, stall}, {63'd0, s});
    m = model_next(s);
    q.push_back(m);
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] tbl [4];
    tbl[0] = 5'd0; tbl[1] = 5'd1; tbl[2] = 5'd8; tbl[3] = 5'd9;
    return tbl[$urandom_range(0, 3)];
  endfunction

  task automatic rnd(input bit force_hold);
    logic [9:0] ct;
    ct = 10'($urandom);
    ct[8] = ($urandom_range(0, 1) == 1);
    apply($urandom_range(0, 4) != 0, pick_reg(), pick_reg(), pick_reg(), $urandom, $urandom, ct,
          $urandom_range(0, 9) == 0, force_hold || ($urandom_range(0, 6) == 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
    chk({tag, "_fields"}, {ex_rs, ex_rt, ex_wrAddr, ex_ctrl, ex_rdData1 | ex_rdData2 | ex_imm | ex_pc4},
        64'd0);
    chk({tag, "_cnt"}, {48'd0, bubble_cnt}, 64'd0);
    chk({tag, "_cnt_small"}, {62'd0, s_bubble_cnt}, 64'd0);
    chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
  endtask

  // Monitor: every posedge that follows a queued decode cycle, compare the EX slot
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.v});
        chk("ex_rs", {59'd0, ex_rs}, {59'd0, e.rs});
        chk("ex_rt", {59'd0, ex_rt}, {59'd0, e.rt});
        chk("ex_wrAddr", {59'd0, ex_wrAddr}, {59'd0, e.wr});
        chk("ex_rdData", {ex_rdData1, ex_rdData2}, {e.d1, e.d2});
        chk("ex_imm_pc4", {ex_imm, ex_pc4}, {e.imm, e.pc4});
        chk("ex_ctrl", {54'd0, ex_ctrl}, {54'd0, e.ctrl});
        chk("bubble_cnt", {48'd0, bubble_cnt}, 64'(e.cnt));
        chk("bubble_cnt_small", {62'd0, s_bubble_cnt}, 64'(e.cnt2));
        chk("small_ex_valid", {63'd0, s_ex_valid}, {63'd0, e.v});
      end
    end
  end

  initial begin
    m = empty_slot(0, 0);
    #1;
    chk_all_zero("reset");

    // plain capture with regDst selecting rd
    apply(1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, CT_ADD, 0, 0);

    // load-use: one bubble, then the dependent add is captured
    apply(1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h200, CT_LW, 0, 0);
    apply(1, 5'd8, 5'd2, 5'd9, 32'h33, 32'h44, CT_ADD, 0, 0);
    apply(1, 5'd8, 5'd2, 5'd9, 32'h33, 32'h44, CT_ADD, 0, 0);

    // load to register 0 never stalls
    apply(1, 5'd1, 5'd0, 5'd0, 32'h55, 32'h66, CT_LW, 0, 0);
    apply(1, 5'd0, 5'd0, 5'd7, 32'h77, 32'h88, CT_ADD, 0, 0);

    // flush beats hold and masks the load-use stall
    apply(1, 5'd1, 5'd8, 5'd0, 32'h99, 32'haa, CT_LW, 0, 0);
    apply(1, 5'd8, 5'd8, 5'd3, 32'hbb, 32'hcc, CT_ADD, 1, 1);

    // hold freezes the slot for three cycles
    apply(1, 5'd2, 5'd3, 5'd4, 32'hdead, 32'hbeef, CT_ADD, 0, 0);
    for (int i = 0; i < 3; i++) rnd(1'b1);

    // four more load-use events: wide counter keeps counting, 2-bit one stops at 3
    for (int i = 0; i < 4; i++) begin
      apply(1, 5'd1, 5'd8, 5'd0, 32'h1000 + i, 32'h2000, CT_LW, 0, 0);
      apply(1, 5'd3, 5'd8, 5'd4, 32'h3000, 32'h4000 + i, CT_ADD, 0, 0);
    end

    // asynchronous reset in mid-cycle while a stall is pending
    apply(1, 5'd1, 5'd8, 5'd0, 32'h5, 32'h6, CT_LW, 0, 0);
    @(negedge clk);
    set_in(1, 5'd8, 5'd2, 5'd3, 32'h7, 32'h8, CT_ADD, 0, 0);
    #1;
    chk("pre_reset_stall", {63'd0, stall}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    m = empty_slot(0, 0);

    for (int i = 0; i < 400; i++) rnd(1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the MIPS pipeline, directly downstream of the register file. The register file drives its read data on the negative edge; this block captures those operands, plus decode control and the immediate, on the next positive edge. It also does load-use hazard detection: it stalls IF/ID and inserts a bubble. It supports branch flush and a downstream hold, and counts inserted bubbles.

Parameters:
DATA_W, 32, operand/immediate/PC width
CTRL_W, 10, width of packed control bundle {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[3:0]}
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_rs  in  5  source 1 address (same value driven to rdAddr1)
id_rt  in  5  source 2 address (same value driven to rdAddr2)
id_rd  in  5  R-type destination
id_rdData1  in  DATA_W  register file read data 1
id_rdData2  in  DATA_W  register file read data 2
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4 of decode instruction
id_ctrl  in  CTRL_W  decode control bundle
flush  in  1  branch/jump resolved taken in EX; kill decode slot
hold  in  1  downstream (memory) stall; freeze this stage
stall  out  1  combinational; freeze PC and IF/ID this cycle
ex_valid  out  1  EX slot valid
ex_rs, ex_rt  out  5 each  captured sources (for forwarding unit)
ex_wrAddr  out  5  resolved destination: regDst ? id_rd : id_rt
ex_rdData1, ex_rdData2  out  DATA_W each  captured operands
ex_imm, ex_pc4  out  DATA_W each  captured immediate / PC+4
ex_ctrl  out  CTRL_W  captured control; all-zero when ex_valid=0
bubble_cnt  out  CNT_W  saturating count of load-use bubbles inserted

Behaviour:
- Reset (async, immediate): every ex_* output = 0, ex_valid = 0, bubble_cnt = 0. stall is then 0 because ex_valid = 0.
- Load-use detect (comb): stall = ex_valid & ex_ctrl.memRead & id_valid & (ex_wrAddr != 0) & (ex_wrAddr == id_rs | ex_wrAddr == id_rt). Do not gate the rt match by instruction type; the spurious stall is accepted.
- stall is forced to 0 when flush = 1, because the decode instruction is dead. hold does not mask stall; IF/ID freezes on either signal.
- Posedge update, highest priority first:
  1. flush: load bubble (ex_valid = 0, ex_ctrl = 0; data fields don't-care, drive 0). This holds even when hold = 1.
  2. hold: keep all registers unchanged.
  3. stall: load bubble and increment bubble_cnt (saturate at all-ones, no wrap).
  4. Otherwise: capture all id_* fields. ex_valid = id_valid. ex_ctrl = id_valid ? id_ctrl : 0.
- Latency: one cycle from decode to EX. The register file writes on posedge and reads on negedge, so a WB write lands in the same cycle's operands and no WB bypass is needed here.
- After a stall the bubble clears ex_valid, so stall deasserts the following cycle. Load-use costs exactly one bubble.
- Register 0: ex_wrAddr = 0 never triggers a stall. ex_ctrl.regWrite passes through unchanged; the WB side ignores writes to register 0.
- Reset mid-stall: stall drops immediately because ex_valid goes to 0 asynchronously.

Decomposition:
- Shared package pipe_pkg: CTRL_W, bit-index constants for each control field, ALUOP encodings, REG_ZERO = 5'd0.
- One sub-module, load_use_detect: purely combinational stall equation, reusable by the IF/ID stage. Everything else lives in id_ex_stage.

Test Plan:
- Reset: assert rst mid-cycle with stage loaded -> all ex_* = 0 and bubble_cnt = 0 immediately, without waiting for a clock edge.
- Plain capture: id_valid = 1, rs = 3, rt = 4, rd = 5, regDst = 1, rdData1 = 0x11, rdData2 = 0x22 -> next edge ex_wrAddr = 5, ex_rdData1 = 0x11, ex_valid = 1, stall = 0.
- Load-use: EX holds lw with ex_wrAddr = 8, decode has rs = 8 -> stall = 1. One bubble is inserted (ex_valid = 0, ex_ctrl = 0) and bubble_cnt goes 0→1. Next cycle stall = 0 and the add is captured.
- Register 0: EX lw with ex_wrAddr = 0, decode rs = 0 -> stall = 0 and no bubble.
- Flush priority: flush = 1 together with hold = 1 and a load-use match -> stall = 0, next edge ex_valid = 0, bubble_cnt unchanged.
- Hold and saturation: hold = 1 for 3 cycles -> ex_* frozen. Preset CNT_W = 2 and force 4 load-use events -> bubble_cnt stops at 3.
